// File: rtl/mmio_mem_responder.sv
// Unified word RAM plus an MMIO window (64-bit cycle counter, output FIFO)
// behind the core's single-cycle memory port.
module mmio_mem_responder #(
  parameter int unsigned RAM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_Data,
  input  logic        Mem_Write,
  output logic [31:0] Read_Data,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam logic [27:0] MMIO_BASE = 28'h800_0000;
  localparam logic [1:0]  REG_CYC_LO = 2'd0;
  localparam logic [1:0]  REG_CYC_HI = 2'd1;
  localparam logic [1:0]  REG_PUSH   = 2'd2;
  localparam logic [1:0]  REG_STATUS = 2'd3;

  logic [31:0]       ram_mem [RAM_WORDS];
  logic [63:0]       cyc_q, cyc_d;
  logic [31:0]       fifo_q [FIFO_DEPTH];
  logic [31:0]       fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_data_q, out_data_d;

  logic              ram_hit_c, mmio_hit_c, ram_we_c;
  logic [1:0]        reg_sel_c;
  logic [RAM_AW-1:0] ram_idx_c;
  logic              push_req_c, push_acc_c, pop_c, full_c, empty_c, ovf_clr_c;
  logic [31:0]       status_c;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^Address[1:0];

  // Address decode: RAM only where all bits above the index are zero, so no aliasing
  assign ram_hit_c  = (Address[31:RAM_AW+2] == '0);
  assign mmio_hit_c = (Address[31:4] == MMIO_BASE);
  assign reg_sel_c  = Address[3:2];
  assign ram_idx_c  = Address[RAM_AW+1:2];
  assign ram_we_c   = Mem_Write & ram_hit_c;

  assign full_c     = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_c    = (count_q == '0);
  assign pop_c      = out_valid_q & out_ready;
  assign push_req_c = Mem_Write & mmio_hit_c & (reg_sel_c == REG_PUSH);
  assign push_acc_c = push_req_c & (~full_c | pop_c);
  assign ovf_clr_c  = Mem_Write & mmio_hit_c & (reg_sel_c == REG_STATUS) & Write_Data[31];
  assign status_c   = {ovf_q, 15'd0, 8'(count_q), 6'd0, full_c, empty_c};

  // Zero-latency read mux
  always_comb begin
    Read_Data = '0;
    if (ram_hit_c) begin
      Read_Data = ram_mem[ram_idx_c];
    end else if (mmio_hit_c) begin
      case (reg_sel_c)
        REG_CYC_LO: Read_Data = cyc_q[31:0];
        REG_CYC_HI: Read_Data = cyc_q[63:32];
        REG_STATUS: Read_Data = status_c;
        default:    Read_Data = '0;
      endcase
    end
  end

  always_comb begin
    cyc_d    = cyc_q + 64'd1;
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_acc_c) begin
      fifo_d[wr_ptr_q] = Write_Data;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_acc_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (push_req_c & full_c & ~pop_c) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_c) begin
      ovf_d = 1'b0;
    end
    // Head after this edge; covers a push landing in the slot being exposed
    out_valid_d = (count_d != '0);
    out_data_d  = fifo_d[rd_ptr_d];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q       <= '0;
      fifo_q      <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      cyc_q       <= cyc_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // RAM contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we_c) begin
      ram_mem[ram_idx_c] <= Write_Data;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_mmio_mem_responder.sv
// Directed bench for mmio_mem_responder: vector table for the memory map,
// hand-written sequences for counter, FIFO and reset corner cases.
module tb_mmio_mem_responder;

  localparam logic [31:0] A_CYC_LO = 32'h8000_0000;
  localparam logic [31:0] A_CYC_HI = 32'h8000_0004;
  localparam logic [31:0] A_PUSH   = 32'h8000_0008;
  localparam logic [31:0] A_STATUS = 32'h8000_000C;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address, Write_Data, Read_Data, out_data;
  logic        Mem_Write, out_valid, out_ready;

  int checks = 0;
  int errors = 0;
  vec_t vecs[18];
  logic [31:0] lo5;

  always #5 clk = ~clk;

  mmio_mem_responder #(
    .RAM_WORDS (1024),
    .FIFO_DEPTH(8),
    .INIT_FILE ("")
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Address   (Address),
    .Write_Data(Write_Data),
    .Mem_Write (Mem_Write),
    .Read_Data (Read_Data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
    Address   = addr;
    Mem_Write = 1'b0;
    #1;
    check(name, Read_Data, exp);
  endtask

  task automatic push(input logic [31:0] d);
    @(negedge clk);
    Address    = A_PUSH;
    Write_Data = d;
    Mem_Write  = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    Mem_Write = 1'b0;
  endtask

  initial begin
    // addr, wdata, we, chk, exp -- applied while reset is held low
    vecs[0]  = '{32'h0000_0010, 32'h1234_5678, 1'b1, 1'b0, 32'h0};
    vecs[1]  = '{32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'h1234_5678};
    vecs[2]  = '{32'h0000_0012, 32'h0,         1'b0, 1'b1, 32'h1234_5678};
    vecs[3]  = '{32'h0000_0000, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0};
    vecs[4]  = '{32'h4000_0000, 32'h0000_DEAD, 1'b1, 1'b0, 32'h0};
    vecs[5]  = '{32'h8000_0010, 32'h0000_DEAD, 1'b1, 1'b0, 32'h0};
    vecs[6]  = '{32'h4000_0000, 32'h0,         1'b0, 1'b1, 32'h0};
    vecs[7]  = '{32'h8000_0010, 32'h0,         1'b0, 1'b1, 32'h0};
    vecs[8]  = '{32'h0000_0000, 32'h0,         1'b0, 1'b1, 32'hCAFE_F00D};
    vecs[9]  = '{32'h0000_0FFC, 32'h55AA_55AA, 1'b1, 1'b0, 32'h0};
    vecs[10] = '{32'h0000_1000, 32'h1111_1111, 1'b1, 1'b0, 32'h0};
    vecs[11] = '{32'h0000_0FFC, 32'h0,         1'b0, 1'b1, 32'h55AA_55AA};
    vecs[12] = '{32'h0000_1000, 32'h0,         1'b0, 1'b1, 32'h0};
    vecs[13] = '{32'h0000_0000, 32'h0,         1'b0, 1'b1, 32'hCAFE_F00D};
    vecs[14] = '{A_PUSH,        32'h0,         1'b0, 1'b1, 32'h0};
    vecs[15] = '{A_STATUS,      32'h0,         1'b0, 1'b1, 32'h0000_0001};
    vecs[16] = '{A_CYC_LO,      32'h0,         1'b0, 1'b1, 32'h0};
    vecs[17] = '{A_CYC_HI,      32'h0,         1'b0, 1'b1, 32'h0};

    reset      = 1'b1;
    Mem_Write  = 1'b0;
    out_ready  = 1'b0;
    Address    = '0;
    Write_Data = '0;
    #1 reset = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", out_data, 32'h0);

    // Memory map vectors; RAM stays writable during reset
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      Address    = vecs[i].addr;
      Write_Data = vecs[i].wdata;
      Mem_Write  = vecs[i].we;
      #1;
      if (vecs[i].chk) check($sformatf("vec%0d", i), Read_Data, vecs[i].exp);
    end
    idle();

    // Cycle counter after release
    reset   = 1'b1;
    Address = A_CYC_LO;
    repeat (5) @(posedge clk);
    #1;
    lo5 = Read_Data;
    check("cyc_lo_rel5", Read_Data, 32'd5);
    repeat (4) @(posedge clk);
    #1;
    check("cyc_lo_rel9", Read_Data, 32'd9);
    check("cyc_lo_delta", Read_Data - lo5, 32'd4);
    rd("cyc_hi", A_CYC_HI, 32'h0);

    // Fill past full with the host stalled
    for (int i = 1; i <= 9; i++) begin
      push(32'(i));
      #1;
      if (i == 1) check("no_fallthrough", 32'(out_valid), 32'h0);
      if (i == 2) begin
        check("valid_after_push", 32'(out_valid), 32'h1);
        check("head_after_push", out_data, 32'd1);
      end
    end
    idle();
    rd("status_full_ovf", A_STATUS, 32'h8000_0802);
    check("head_stable", out_data, 32'd1);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("drain_valid%0d", i), 32'(out_valid), 32'h1);
      check($sformatf("drain_data%0d", i), out_data, 32'(i));
      @(negedge clk);
      #1;
    end
    check("drained_valid", 32'(out_valid), 32'h0);
    out_ready = 1'b0;
    rd("status_empty_ovf", A_STATUS, 32'h8000_0001);
    @(negedge clk);
    Address    = A_STATUS;
    Write_Data = 32'h8000_0000;
    Mem_Write  = 1'b1;
    idle();
    rd("status_ovf_clr", A_STATUS, 32'h0000_0001);

    // Push and pop on the same edge while full
    for (int i = 0; i < 8; i++) push(32'h10 + 32'(i));
    @(negedge clk);
    Address    = A_PUSH;
    Write_Data = 32'hAA;
    Mem_Write  = 1'b1;
    out_ready  = 1'b1;
    #1;
    check("full_head", out_data, 32'h10);
    @(negedge clk);
    Mem_Write = 1'b0;
    out_ready = 1'b0;
    rd("status_pushpop", A_STATUS, 32'h0000_0802);
    out_ready = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      check($sformatf("pp_data%0d", j), out_data, 32'h10 + 32'(j));
      @(negedge clk);
      #1;
    end
    check("pp_last_valid", 32'(out_valid), 32'h1);
    check("pp_last_data", out_data, 32'hAA);
    @(negedge clk);
    #1;
    check("pp_empty_valid", 32'(out_valid), 32'h0);
    out_ready = 1'b0;

    // Asynchronous reset mid-stream
    push(32'h1);
    push(32'h2);
    push(32'h3);
    idle();
    #1;
    check("pre_rst_valid", 32'(out_valid), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'h0);
    check("async_rst_data", out_data, 32'h0);
    rd("status_in_rst", A_STATUS, 32'h0000_0001);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    rd("status_after_rel", A_STATUS, 32'h0000_0001);
    check("valid_after_rel", 32'(out_valid), 32'h0);
    rd("cyc_after_rel", A_CYC_LO, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
